// File: rtl/axis_packetizer.sv
// axis_packetizer: FWFT FIFO packetizer (aclk/areset, enable, log_packet_length, S_AXIS in, M_AXIS out with tlast, overflow_count)
module axis_packetizer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH_LOG   = 4
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        enable,
    input  logic [4:0]                  log_packet_length,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tlast,
    output logic [15:0]                 overflow_count
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    logic [AXIS_TDATA_WIDTH-1:0] mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_q, wr_d, rd_q, rd_d;
    logic full_q, full_d, empty, push, drop, pop;
    logic [15:0] ovf_q, ovf_d, beat_q, beat_d, len_q, len_d, live_m1, last_m1;
    logic [4:0] log_c;
    logic [16:0] pow;
    always_comb begin
        empty = wr_q == rd_q && !full_q;
        S_AXIS_tready = !areset;
        M_AXIS_tvalid = !areset && !empty;
        M_AXIS_tdata = M_AXIS_tvalid ? mem_q[rd_q] : '0;
        push = S_AXIS_tready && S_AXIS_tvalid && enable && !full_q;
        drop = S_AXIS_tready && S_AXIS_tvalid && enable && full_q;
        pop = M_AXIS_tvalid && M_AXIS_tready;
        log_c = log_packet_length > 5'd16 ? 5'd16 : log_packet_length;
        pow = 17'd1 << log_c;
        live_m1 = 16'(pow - 17'd1);
        last_m1 = beat_q == '0 ? live_m1 : len_q;
        M_AXIS_tlast = M_AXIS_tvalid && beat_q == last_m1;
        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
        full_d = push && !pop ? wr_d == rd_q : pop && !push ? 1'b0 : full_q;
        ovf_d = drop && ovf_q != 16'hFFFF ? ovf_q + 16'd1 : ovf_q;
        beat_d = pop ? (M_AXIS_tlast ? '0 : beat_q + 16'd1) : beat_q;
        len_d = pop && beat_q == '0 ? live_m1 : len_q;
        overflow_count = ovf_q;
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_q <= '0;
            rd_q <= '0;
            full_q <= 1'b0;
            ovf_q <= '0;
            beat_q <= '0;
            len_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            full_q <= full_d;
            ovf_q <= ovf_d;
            beat_q <= beat_d;
            len_q <= len_d;
        end
    end
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_q] <= S_AXIS_tdata;
    end
endmodule

// File: tb/tb_axis_packetizer.sv
// tb_axis_packetizer: randomized and directed checks of axis_packetizer against a queue-based packet model
module tb_axis_packetizer;
    logic aclk, areset, enable, S_AXIS_tvalid, S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tready, M_AXIS_tlast;
    logic [4:0] log_packet_length;
    logic [31:0] S_AXIS_tdata, M_AXIS_tdata;
    logic [15:0] overflow_count;
    int errors = 0, checks = 0;
    logic [31:0] q[$];
    int beat = 0, plen = 1, ovf = 0;
    axis_packetizer #(.AXIS_TDATA_WIDTH(32), .FIFO_DEPTH_LOG(4)) dut (
        .aclk(aclk), .areset(areset), .enable(enable), .log_packet_length(log_packet_length),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
        .M_AXIS_tlast(M_AXIS_tlast), .overflow_count(overflow_count)
    );
    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int pkt_len(input logic [4:0] lg);
        return 1 << (lg > 16 ? 16 : int'(lg));
    endfunction
    task automatic cyc(input logic rst, input logic v, input logic [31:0] d, input logic en, input logic rdy, input logic [4:0] lg);
        logic ev;
        int cur, sz;
        areset = rst; S_AXIS_tvalid = v; S_AXIS_tdata = d; enable = en; M_AXIS_tready = rdy; log_packet_length = lg;
        #2;
        ev = !rst && q.size() > 0;
        cur = beat == 0 ? pkt_len(lg) : plen;
        chk("tready", {31'd0, S_AXIS_tready}, {31'd0, !rst});
        chk("tvalid", {31'd0, M_AXIS_tvalid}, {31'd0, ev});
        chk("tdata", M_AXIS_tdata, ev ? q[0] : 32'd0);
        chk("tlast", {31'd0, M_AXIS_tlast}, {31'd0, ev && beat == cur - 1});
        chk("overflow", {16'd0, overflow_count}, ovf);
        @(posedge aclk);
        if (rst) begin
            q.delete(); beat = 0; plen = 1; ovf = 0;
        end else begin
            sz = q.size();
            if (sz > 0 && rdy) begin
                if (beat == 0) plen = pkt_len(lg);
                void'(q.pop_front());
                beat = beat == plen - 1 ? 0 : beat + 1;
            end
            if (v && en) begin
                if (sz < 16) q.push_back(d);
                else if (ovf < 65535) ovf++;
            end
        end
        #1;
    endtask
    initial begin
        logic [4:0] lg;
        logic r;
        repeat (2) cyc(1, 0, 0, 1, 1, 2);
        for (int i = 1; i <= 8; i++) cyc(0, 1, i, 1, 1, 2);
        repeat (3) cyc(0, 0, 0, 1, 1, 2);
        for (int i = 0; i < 20; i++) cyc(0, 1, 100 + i, 1, 0, 2);
        chk("ovf_after_fill", {16'd0, overflow_count}, 4);
        repeat (18) cyc(0, 0, 0, 1, 1, 2);
        for (int i = 0; i < 12; i++) cyc(0, i < 4, 10 + i, 1, i[0] == 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 200 + i, 1, 0, 2);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1, i < 2 ? 5'd2 : 5'd1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 300 + i, 0, 1, 2);
        for (int i = 0; i < 6; i++) cyc(0, i < 4, 400 + i, 1, 1, 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 500 + i, 1, $urandom_range(0, 1) == 1, 31);
        cyc(1, 0, 0, 1, 1, 2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 600 + i, 1, 1, 2);
        cyc(0, 0, 0, 1, 1, 2);
        for (int i = 0; i < 2; i++) cyc(0, 1, 610 + i, 1, 0, 2);
        cyc(1, 1, 700, 1, 1, 2);
        chk("fifo_empty_after_reset", {31'd0, M_AXIS_tvalid}, 0);
        for (int i = 0; i < 8; i++) cyc(0, i < 4, 800 + i, 1, 1, 2);
        lg = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) lg = 5'($urandom_range(0, 5));
            r = $urandom_range(0, 199) == 0;
            cyc(r, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, lg);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
